// File: rtl/rotation_parser.sv
// Parses ASCII rotation lines ("L68\n", "R5\n") into signed 32-bit words
// written one per line to a BRAM port.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DIR    | expecting 'L'/'R' (blank lines and CR skipped)
// DIGITS | accumulating decimal magnitude
// WRITE  | one-cycle BRAM write of the signed value
// DONE   | parse complete, results held
// ERR    | format error, draining input until s_last
module rotation_parser #(
  parameter int MAX_ENTRIES = 4096,
  parameter int MAX_DIGITS  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_din,
  output logic [31:0] size_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1) + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DIR    = 3'd1;
  localparam logic [2:0] ST_DIGITS = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  logic [2:0]    state;
  logic [31:0]   mag;
  logic          neg;
  logic          last_line;
  logic [CW-1:0] ndig;

  logic          accept;
  logic          is_digit;
  logic          is_nl;
  logic          is_cr;
  logic          is_dir;
  logic          full;
  logic          digit_room;
  logic [2:0]    fail_state;
  logic [7:0]    digit_byte;
  logic [31:0]   digit_val;

  assign s_ready    = (state == ST_DIR) || (state == ST_DIGITS) || (state == ST_ERR);
  assign accept     = s_valid && s_ready;
  assign is_digit   = (s_data >= 8'h30) && (s_data <= 8'h39);
  assign is_nl      = (s_data == 8'h0A);
  assign is_cr      = (s_data == 8'h0D);
  assign is_dir     = (s_data == 8'h4C) || (s_data == 8'h52);
  assign full       = (size_o == 32'(MAX_ENTRIES));
  assign digit_room = (ndig != CW'(MAX_DIGITS));
  assign digit_byte = s_data - 8'h30;
  assign digit_val  = {24'd0, digit_byte};
  // An error on the byte carrying s_last has nothing left to drain.
  assign fail_state = s_last ? ST_DONE : ST_ERR;

  assign bram_en   = (state == ST_WRITE);
  assign bram_we   = {4{bram_en}};
  assign bram_addr = bram_en ? {size_o[29:0], 2'b00} : 32'd0;
  assign bram_din  = bram_en ? (neg ? (32'd0 - mag) : mag) : 32'd0;
  assign done_o    = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mag       <= 32'd0;
      neg       <= 1'b0;
      last_line <= 1'b0;
      ndig      <= '0;
      size_o    <= 32'd0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_DIR;
            size_o <= 32'd0;
            mag    <= 32'd0;
            err_o  <= 1'b0;
          end
        end
        ST_DIR: begin
          if (accept) begin
            if (is_cr || is_nl) begin
              if (s_last) state <= ST_DONE;
            end else if (is_dir && !s_last) begin
              neg   <= (s_data == 8'h4C);
              mag   <= 32'd0;
              ndig  <= '0;
              state <= ST_DIGITS;
            end else begin
              state <= fail_state;
              err_o <= s_last;
            end
          end
        end
        ST_DIGITS: begin
          if (accept) begin
            if (is_digit && digit_room) begin
              mag  <= mag * 32'd10 + digit_val;
              ndig <= ndig + CW'(1);
              if (s_last && full) begin
                state <= ST_DONE;
                err_o <= 1'b1;
              end else if (s_last) begin
                state     <= ST_WRITE;
                last_line <= 1'b1;
              end
            end else if (is_cr && !s_last) begin
              state <= ST_DIGITS;
            end else if ((is_nl || is_cr) && (ndig != '0) && !full) begin
              state     <= ST_WRITE;
              last_line <= s_last;
            end else begin
              state <= fail_state;
              err_o <= s_last;
            end
          end
        end
        ST_WRITE: begin
          size_o <= size_o + 32'd1;
          state  <= last_line ? ST_DONE : ST_DIR;
        end
        ST_ERR: begin
          if (accept && s_last) begin
            state <= ST_DONE;
            err_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_parser.sv
// Directed bench for rotation_parser: a default-parameter instance plus a
// MAX_ENTRIES=2 instance, each selected onto the shared stimulus driver.
module tb_rotation_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        sel2 = 1'b0;

  logic        s_ready, bram_en, done_o, err_o;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_din, size_o;
  logic        s_ready2, bram_en2, done2, err2;
  logic [3:0]  bram_we2;
  logic [31:0] bram_addr2, bram_din2, size2;

  logic ready_sel, done_sel;
  assign ready_sel = sel2 ? s_ready2 : s_ready;
  assign done_sel  = sel2 ? done2 : done_o;

  int total = 0;
  int bad = 0;
  int stall_err = 0;
  int we_bad = 0;
  int wr_cnt = 0;
  int wr2_cnt = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [31:0] wr2_data [16];

  rotation_parser dut (
    .clk(clk), .rst(rst), .start(start && !sel2), .s_data(s_data),
    .s_valid(s_valid && !sel2), .s_last(s_last), .s_ready(s_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .size_o(size_o), .done_o(done_o), .err_o(err_o)
  );

  rotation_parser #(.MAX_ENTRIES(2), .MAX_DIGITS(6)) dut2 (
    .clk(clk), .rst(rst), .start(start && sel2), .s_data(s_data),
    .s_valid(s_valid && sel2), .s_last(s_last), .s_ready(s_ready2),
    .bram_en(bram_en2), .bram_we(bram_we2), .bram_addr(bram_addr2),
    .bram_din(bram_din2), .size_o(size2), .done_o(done2), .err_o(err2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we !== 4'hF) we_bad++;
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = bram_addr;
        wr_data[wr_cnt] = bram_din;
      end
      wr_cnt++;
    end
    if (bram_en2) begin
      if (bram_we2 !== 4'hF) we_bad++;
      if (wr2_cnt < 16) wr2_data[wr2_cnt] = bram_din2;
      wr2_cnt++;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0;
    wr2_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns at the negedge following its transfer.
  task automatic send_byte(input logic [7:0] b, input logic last);
    bit acc = 0;
    bit rdy;
    int n = 0;
    s_data = b;
    s_valid = 1'b1;
    s_last = last;
    while (!acc && n < 50) begin
      rdy = ready_sel;
      @(posedge clk);
      @(negedge clk);
      acc = rdy;
      n++;
    end
    if (!acc) stall_err++;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps, input bit mark_last);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(s[i], mark_last && (i == s.len() - 1));
    end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_sel !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (done_sel === 1'b1);
  endtask

  task automatic test_reset();
    #2;
    total += 8;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
    if (bram_en !== 1'b0) begin bad++; $display("FAIL reset_bram_en got=%b want=0", bram_en); end
    if (bram_we !== 4'h0) begin bad++; $display("FAIL reset_bram_we got=%h want=0", bram_we); end
    if (bram_addr !== 32'd0) begin bad++; $display("FAIL reset_bram_addr got=%h want=0", bram_addr); end
    if (bram_din !== 32'd0) begin bad++; $display("FAIL reset_bram_din got=%h want=0", bram_din); end
    if (size_o !== 32'd0) begin bad++; $display("FAIL reset_size got=%0d want=0", size_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int exp [11] = '{-68, -30, 48, -5, 60, -55, -1, -99, 14, -82, -32};
    bit ok;
    clear_mon();
    pulse_start();
    send_str("L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\nL32", 1'b0, 1'b1);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL seq_done got=%b want=1", done_o); end
    total++;
    if (wr_cnt !== 11) begin bad++; $display("FAIL seq_writes got=%0d want=11", wr_cnt); end
    for (int i = 0; i < 11 && i < wr_cnt; i++) begin
      total += 2;
      if (wr_addr[i] !== 32'(i * 4)) begin
        bad++; $display("FAIL seq_addr[%0d] got=%0d want=%0d", i, wr_addr[i], i * 4);
      end
      if (wr_data[i] !== 32'(exp[i])) begin
        bad++; $display("FAIL seq_data[%0d] got=%0d want=%0d", i, $signed(wr_data[i]), exp[i]);
      end
    end
    total += 3;
    if (size_o !== 32'd11) begin bad++; $display("FAIL seq_size got=%0d want=11", size_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL seq_err got=%b want=0", err_o); end
    if (we_bad !== 0) begin bad++; $display("FAIL seq_we got=%0d bad strobes want=0", we_bad); end
  endtask

  task automatic test_cr_blank_gaps();
    bit ok;
    clear_mon();
    pulse_start();
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL restart_done_clear got=%b want=0", done_o); end
    send_str("R7\r\n\nL0\n", 1'b1, 1'b1);
    wait_done(ok);
    total += 5;
    if (!ok) begin bad++; $display("FAIL cr_done got=%b want=1", done_o); end
    if (wr_cnt !== 2) begin bad++; $display("FAIL cr_writes got=%0d want=2", wr_cnt); end
    else begin
      total += 2;
      if (wr_data[0] !== 32'd7) begin bad++; $display("FAIL cr_data0 got=%0d want=7", wr_data[0]); end
      if (wr_data[1] !== 32'd0) begin bad++; $display("FAIL cr_data1 got=%0d want=0", wr_data[1]); end
    end
    if (size_o !== 32'd2) begin bad++; $display("FAIL cr_size got=%0d want=2", size_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL cr_err got=%b want=0", err_o); end
    if (stall_err !== 0) begin bad++; $display("FAIL cr_stall got=%0d want=0", stall_err); end
  endtask

  task automatic test_format_err();
    bit ok;
    clear_mon();
    pulse_start();
    send_str("R12X4\nL3\n", 1'b0, 1'b1);
    wait_done(ok);
    total += 5;
    if (!ok) begin bad++; $display("FAIL fmt_done got=%b want=1", done_o); end
    if (err_o !== 1'b1) begin bad++; $display("FAIL fmt_err got=%b want=1", err_o); end
    if (size_o !== 32'd0) begin bad++; $display("FAIL fmt_size got=%0d want=0", size_o); end
    if (wr_cnt !== 0) begin bad++; $display("FAIL fmt_writes got=%0d want=0", wr_cnt); end
    if (stall_err !== 0) begin bad++; $display("FAIL fmt_stall got=%0d want=0", stall_err); end
  endtask

  task automatic test_max_digits();
    bit ok;
    clear_mon();
    pulse_start();
    send_str("L1234567\n", 1'b0, 1'b1);
    wait_done(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL dig7_done got=%b want=1", done_o); end
    if (err_o !== 1'b1) begin bad++; $display("FAIL dig7_err got=%b want=1", err_o); end
    if (size_o !== 32'd0) begin bad++; $display("FAIL dig7_size got=%0d want=0", size_o); end
    if (wr_cnt !== 0) begin bad++; $display("FAIL dig7_writes got=%0d want=0", wr_cnt); end

    clear_mon();
    pulse_start();
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL restart_err_clear got=%b want=0", err_o); end
    send_str("R999999\n", 1'b0, 1'b1);
    total += 5;
    if (bram_en !== 1'b1) begin bad++; $display("FAIL dig6_latency_en got=%b want=1", bram_en); end
    if (bram_we !== 4'hF) begin bad++; $display("FAIL dig6_we got=%h want=f", bram_we); end
    if (bram_addr !== 32'd0) begin bad++; $display("FAIL dig6_addr got=%0d want=0", bram_addr); end
    if (bram_din !== 32'd999999) begin bad++; $display("FAIL dig6_din got=%0d want=999999", bram_din); end
    if (s_ready !== 1'b0) begin bad++; $display("FAIL write_ready got=%b want=0", s_ready); end
    wait_done(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL dig6_done got=%b want=1", done_o); end
    if (size_o !== 32'd1) begin bad++; $display("FAIL dig6_size got=%0d want=1", size_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL dig6_err got=%b want=0", err_o); end
    if (wr_cnt !== 1) begin bad++; $display("FAIL dig6_writes got=%0d want=1", wr_cnt); end
  endtask

  task automatic test_max_entries();
    bit ok;
    sel2 = 1'b1;
    clear_mon();
    pulse_start();
    send_str("R1\nR2\nR3\n", 1'b0, 1'b1);
    wait_done(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL full_done got=%b want=1", done2); end
    if (wr2_cnt !== 2) begin bad++; $display("FAIL full_writes got=%0d want=2", wr2_cnt); end
    else begin
      total += 2;
      if (wr2_data[0] !== 32'd1) begin bad++; $display("FAIL full_data0 got=%0d want=1", wr2_data[0]); end
      if (wr2_data[1] !== 32'd2) begin bad++; $display("FAIL full_data1 got=%0d want=2", wr2_data[1]); end
    end
    if (size2 !== 32'd2) begin bad++; $display("FAIL full_size got=%0d want=2", size2); end
    if (err2 !== 1'b1) begin bad++; $display("FAIL full_err got=%b want=1", err2); end
    sel2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored_and_abort();
    bit ok;
    clear_mon();
    pulse_start();
    send_str("R1", 1'b0, 1'b0);
    pulse_start();
    send_str("2\n", 1'b0, 1'b1);
    wait_done(ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL ign_done got=%b want=1", done_o); end
    if (wr_cnt !== 1) begin bad++; $display("FAIL ign_writes got=%0d want=1", wr_cnt); end
    else begin
      total++;
      if (wr_data[0] !== 32'd12) begin bad++; $display("FAIL ign_data got=%0d want=12", wr_data[0]); end
    end
    if (size_o !== 32'd1) begin bad++; $display("FAIL ign_size got=%0d want=1", size_o); end

    clear_mon();
    pulse_start();
    send_str("L34", 1'b0, 1'b0);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL digits_ready got=%b want=1", s_ready); end
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", s_ready); end
    if (size_o !== 32'd0) begin bad++; $display("FAIL abort_size got=%0d want=0", size_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done_o); end
    if (bram_en !== 1'b0) begin bad++; $display("FAIL abort_en got=%b want=0", bram_en); end
    @(negedge clk);
    rst = 1'b0;
    s_data = 8'h0A;
    s_valid = 1'b1;
    s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total += 2;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL post_rst_ready[%0d] got=%b want=0", i, s_ready); end
      if (bram_en !== 1'b0) begin bad++; $display("FAIL post_rst_en[%0d] got=%b want=0", i, bram_en); end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    total += 2;
    if (done_o !== 1'b0) begin bad++; $display("FAIL post_rst_done got=%b want=0", done_o); end
    if (wr_cnt !== 0) begin bad++; $display("FAIL post_rst_writes got=%0d want=0", wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_cr_blank_gaps();
    test_format_err();
    test_max_digits();
    test_max_entries();
    test_start_ignored_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
